// File: rtl/mem_access_ctrl.sv
// Load/store unit between the MEM stage and a word-wide memory port.
// Checks size and alignment, builds byte lanes for stores, and extends
// loaded bytes and halfwords. IDLE -> ACCESS -> DONE, with a timeout on ACCESS.
// Handshake: mem_req_o stays high with stable address/be/wdata/we from the
// first ACCESS cycle until mem_ack_i is sampled high on a rising edge.
// The request is also dropped if no ack arrives within TIMEOUT_CYCLES.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Mem_R_i,
   input  logic        Mem_W_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] Addr_i,
   input  logic [31:0] Data_to_memory,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   output logic [31:0] Load_data_o,
   output logic        Load_valid_o,
   output logic        Stall_o,
   output logic        Error_o,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

   // The counter only needs to reach TIMEOUT_CYCLES-1, which marks the last ACCESS cycle.
   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          load_q;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;

   logic          f3_legal, aligned, req_any, req_ok, req_bad;
   logic [3:0]    be_d;
   logic [31:0]   wdata_d;
   logic [31:0]   shifted;
   logic [15:0]   half_sel;
   logic [31:0]   load_ext_d;

   // Decode the incoming request: legality, alignment and store byte lanes.
   always_comb begin
      f3_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                 (funct3_i == 3'b100) || (funct3_i == 3'b101);
      aligned  = 1'b1;
      be_d     = 4'b1111;
      wdata_d  = Data_to_memory;
      case (funct3_i[1:0])
         2'b00: begin
            be_d    = 4'b0001 << Addr_i[1:0];
            wdata_d = {4{Data_to_memory[7:0]}};
         end
         2'b01: begin
            aligned = ~Addr_i[0];
            be_d    = Addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{Data_to_memory[15:0]}};
         end
         2'b10: aligned = (Addr_i[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      req_any = Mem_R_i | Mem_W_i;
      req_ok  = req_any & f3_legal & aligned;
      req_bad = req_any & ~(f3_legal & aligned);
   end

   // Select and extend the loaded byte/half using the latched offset and size.
   always_comb begin
      shifted    = mem_rdata_i >> {off_q, 3'b000};
      half_sel   = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      case (f3_q)
         3'b000:  load_ext_d = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_ext_d = {24'd0, shifted[7:0]};
         3'b001:  load_ext_d = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_ext_d = {16'd0, half_sel};
         default: load_ext_d = mem_rdata_i;
      endcase
   end

   // Stall as soon as a good request is seen, and for the whole access.
   assign Stall_o     = ((state_q == IDLE) && req_ok) || (state_q == ACCESS);
   assign dbg_state_o = state_q;

   // Main FSM with registered memory-port and writeback outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         load_q       <= 1'b0;
         f3_q         <= 3'b000;
         off_q        <= 2'b00;
         mem_req_o    <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= 32'd0;
         mem_be_o     <= 4'd0;
         mem_wdata_o  <= 32'd0;
         Load_data_o  <= 32'd0;
         Load_valid_o <= 1'b0;
         Error_o      <= 1'b0;
      end else begin
         Load_valid_o <= 1'b0;
         Error_o      <= 1'b0;
         case (state_q)
            IDLE: begin
               Error_o <= req_bad;
               if (req_ok) begin
                  mem_addr_o  <= {Addr_i[31:2], 2'b00};
                  mem_be_o    <= be_d;
                  mem_wdata_o <= wdata_d;
                  mem_we_o    <= Mem_W_i;
                  load_q      <= ~Mem_W_i;
                  f3_q        <= funct3_i;
                  off_q       <= Addr_i[1:0];
                  cnt_q       <= '0;
                  mem_req_o   <= 1'b1;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               // An ack wins over a timeout landing in the same cycle.
               if (mem_ack_i) begin
                  mem_req_o <= 1'b0;
                  state_q   <= DONE;
                  if (load_q) begin
                     Load_data_o  <= load_ext_d;
                     Load_valid_o <= 1'b1;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  mem_req_o   <= 1'b0;
                  Load_data_o <= 32'd0;
                  Error_o     <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl, built with TIMEOUT_CYCLES = 4.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        Mem_R_i, Mem_W_i;
   logic [2:0]  funct3_i;
   logic [31:0] Addr_i, Data_to_memory;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;
   logic [31:0] Load_data_o;
   logic        Load_valid_o, Stall_o, Error_o;
   logic [1:0]  dbg_state_o;

   localparam logic [1:0] S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2;

   int n_total = 0;
   int n_pass  = 0;

   // clock / reset
   always #5 clk = ~clk;

   mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .Mem_R_i(Mem_R_i), .Mem_W_i(Mem_W_i),
      .funct3_i(funct3_i), .Addr_i(Addr_i), .Data_to_memory(Data_to_memory),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .mem_ack_i(mem_ack_i), .Load_data_o(Load_data_o), .Load_valid_o(Load_valid_o),
      .Stall_o(Stall_o), .Error_o(Error_o), .dbg_state_o(dbg_state_o)
   );

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic        st;
      logic [31:0] addr;
      logic [31:0] d;
      logic [31:0] rdata;
      logic        err;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] ld;
   } vec_t;

   vec_t vecs[$];

   // scoreboard compare
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic idle_inputs();
      Mem_R_i = 0; Mem_W_i = 0; funct3_i = 3'b000; Addr_i = 0; Data_to_memory = 0;
   endtask

   // driver: start a request at a negedge, hold it for one clock edge
   task automatic drive_req(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      Mem_R_i = rd; Mem_W_i = wr; funct3_i = f3; Addr_i = a; Data_to_memory = d;
      #1;
   endtask

   // one table entry: ack in the first ACCESS cycle, or an error case
   task automatic run_vec(input vec_t v);
      drive_req(~v.st, v.st, v.f3, v.addr, v.d);
      chk({v.name, " stall_req"}, Stall_o, !v.err);
      @(negedge clk);
      if (v.err) begin
         chk({v.name, " state"}, dbg_state_o, S_IDLE);
         chk({v.name, " req"}, mem_req_o, 0);
         chk({v.name, " err"}, Error_o, 1);
         idle_inputs();
         @(negedge clk);
         chk({v.name, " err_pulse"}, Error_o, 0);
      end else begin
         chk({v.name, " state"}, dbg_state_o, S_ACCESS);
         chk({v.name, " req"}, mem_req_o, 1);
         chk({v.name, " we"}, mem_we_o, v.st);
         chk({v.name, " addr"}, mem_addr_o, {v.addr[31:2], 2'b00});
         chk({v.name, " be"}, mem_be_o, v.be);
         if (v.st) chk({v.name, " wdata"}, mem_wdata_o, v.wdata);
         idle_inputs();
         mem_ack_i = 1; mem_rdata_i = v.rdata;
         #1 chk({v.name, " stall_acc"}, Stall_o, 1);
         @(negedge clk);
         mem_ack_i = 0;
         chk({v.name, " done"}, dbg_state_o, S_DONE);
         chk({v.name, " req_drop"}, mem_req_o, 0);
         chk({v.name, " stall_done"}, Stall_o, 0);
         chk({v.name, " valid"}, Load_valid_o, !v.st);
         chk({v.name, " err0"}, Error_o, 0);
         if (!v.st) chk({v.name, " ldata"}, Load_data_o, v.ld);
         @(negedge clk);
         chk({v.name, " back_idle"}, dbg_state_o, S_IDLE);
         chk({v.name, " valid_pulse"}, Load_valid_o, 0);
      end
   endtask

   function automatic vec_t mk(string n, logic [2:0] f3, logic st, logic [31:0] a,
                               logic [31:0] d, logic [31:0] rd, logic err,
                               logic [3:0] be, logic [31:0] wd, logic [31:0] ld);
      vec_t v;
      v.name = n; v.f3 = f3; v.st = st; v.addr = a; v.d = d; v.rdata = rd;
      v.err = err; v.be = be; v.wdata = wd; v.ld = ld;
      return v;
   endfunction

   initial begin
      vecs.push_back(mk("LB_neg",  3'b000, 0, 32'h1003, 0, 32'h80FF_0000, 0, 4'b1000, 0, 32'hFFFF_FF80));
      vecs.push_back(mk("LB_pos",  3'b000, 0, 32'h1000, 0, 32'h0000_007F, 0, 4'b0001, 0, 32'h0000_007F));
      vecs.push_back(mk("LBU",     3'b100, 0, 32'h1001, 0, 32'h0000_F600, 0, 4'b0010, 0, 32'h0000_00F6));
      vecs.push_back(mk("LH",      3'b001, 0, 32'h0002, 0, 32'h8001_0000, 0, 4'b1100, 0, 32'hFFFF_8001));
      vecs.push_back(mk("LHU",     3'b101, 0, 32'h0000, 0, 32'h0000_9ABC, 0, 4'b0011, 0, 32'h0000_9ABC));
      vecs.push_back(mk("LW",      3'b010, 0, 32'h0010, 0, 32'hCAFE_BABE, 0, 4'b1111, 0, 32'hCAFE_BABE));
      vecs.push_back(mk("SB",      3'b000, 1, 32'h2001, 32'h0000_00A5, 0, 0, 4'b0010, 32'hA5A5_A5A5, 0));
      vecs.push_back(mk("SH_lo",   3'b001, 1, 32'h2000, 32'h1234_ABCD, 0, 0, 4'b0011, 32'hABCD_ABCD, 0));
      vecs.push_back(mk("SW",      3'b010, 1, 32'h2004, 32'hDEAD_BEEF, 0, 0, 4'b1111, 32'hDEAD_BEEF, 0));
      vecs.push_back(mk("LW_mis",  3'b010, 0, 32'h0006, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk("LH_mis",  3'b001, 0, 32'h0001, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk("SH_mis",  3'b001, 1, 32'h0003, 32'h1111_2222, 0, 1, 0, 0, 0));
      vecs.push_back(mk("f3_011",  3'b011, 0, 32'h0000, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk("f3_110",  3'b110, 1, 32'h0000, 0, 0, 1, 0, 0, 0));

      // reset state
      idle_inputs();
      mem_ack_i = 0; mem_rdata_i = 0;
      reset = 1;
      repeat (2) @(negedge clk);
      chk("rst state", dbg_state_o, S_IDLE);
      chk("rst req", mem_req_o, 0);
      chk("rst addr", mem_addr_o, 0);
      chk("rst be", mem_be_o, 0);
      chk("rst wdata", mem_wdata_o, 0);
      chk("rst ldata", Load_data_o, 0);
      chk("rst valid", Load_valid_o, 0);
      chk("rst err", Error_o, 0);
      chk("rst stall", Stall_o, 0);
      reset = 0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // ack outside ACCESS is ignored
      @(negedge clk);
      mem_ack_i = 1; mem_rdata_i = 32'h5555_5555;
      repeat (2) @(negedge clk);
      chk("stray_ack state", dbg_state_o, S_IDLE);
      chk("stray_ack valid", Load_valid_o, 0);
      chk("stray_ack ldata", Load_data_o, 32'hCAFE_BABE);
      mem_ack_i = 0;

      // SH with ack in the third ACCESS cycle; request held stable meanwhile
      drive_req(0, 1, 3'b001, 32'h2002, 32'h1234_ABCD);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         idle_inputs();
         chk($sformatf("SH3 req c%0d", c), mem_req_o, 1);
         chk($sformatf("SH3 addr c%0d", c), mem_addr_o, 32'h2000);
         chk($sformatf("SH3 be c%0d", c), mem_be_o, 4'b1100);
         chk($sformatf("SH3 wdata c%0d", c), mem_wdata_o, 32'hABCD_ABCD);
         chk($sformatf("SH3 we c%0d", c), mem_we_o, 1);
         if (c == 3) mem_ack_i = 1;
      end
      @(negedge clk);
      mem_ack_i = 0;
      chk("SH3 done", dbg_state_o, S_DONE);
      chk("SH3 req_drop", mem_req_o, 0);
      chk("SH3 valid", Load_valid_o, 0);
      chk("SH3 err", Error_o, 0);

      // LW with ack on the last allowed cycle: counts as ack, no error
      drive_req(1, 0, 3'b010, 32'h0040, 0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         idle_inputs();
         chk($sformatf("LWlast req c%0d", c), mem_req_o, 1);
         if (c == 4) begin mem_ack_i = 1; mem_rdata_i = 32'h0BAD_F00D; end
      end
      @(negedge clk);
      mem_ack_i = 0;
      chk("LWlast done", dbg_state_o, S_DONE);
      chk("LWlast valid", Load_valid_o, 1);
      chk("LWlast err", Error_o, 0);
      chk("LWlast ldata", Load_data_o, 32'h0BAD_F00D);

      // LHU timeout: four ACCESS cycles, then error with zeroed load data
      drive_req(1, 0, 3'b101, 32'h0004, 0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         idle_inputs();
         chk($sformatf("TO req c%0d", c), mem_req_o, 1);
         chk($sformatf("TO stall c%0d", c), Stall_o, 1);
      end
      @(negedge clk);
      chk("TO done", dbg_state_o, S_DONE);
      chk("TO req_drop", mem_req_o, 0);
      chk("TO err", Error_o, 1);
      chk("TO ldata", Load_data_o, 0);
      chk("TO valid", Load_valid_o, 0);
      @(negedge clk);
      chk("TO idle", dbg_state_o, S_IDLE);
      chk("TO err_pulse", Error_o, 0);

      // both flags high: treated as a store
      drive_req(1, 1, 3'b010, 32'h3000, 32'hDEAD_BEEF);
      @(negedge clk);
      idle_inputs();
      chk("RW we", mem_we_o, 1);
      chk("RW be", mem_be_o, 4'b1111);
      chk("RW wdata", mem_wdata_o, 32'hDEAD_BEEF);
      mem_ack_i = 1;
      @(negedge clk);
      mem_ack_i = 0;
      chk("RW valid", Load_valid_o, 0);
      @(negedge clk);

      // reset in the middle of an access
      drive_req(1, 0, 3'b010, 32'h0100, 0);
      @(negedge clk);
      idle_inputs();
      chk("RST_mid req_before", mem_req_o, 1);
      reset = 1;
      #1;
      chk("RST_mid req", mem_req_o, 0);
      chk("RST_mid state", dbg_state_o, S_IDLE);
      chk("RST_mid valid", Load_valid_o, 0);
      chk("RST_mid err", Error_o, 0);
      @(negedge clk);
      reset = 0;
      mem_ack_i = 1;
      repeat (2) @(negedge clk);
      chk("RST_mid no_valid", Load_valid_o, 0);
      chk("RST_mid still_idle", dbg_state_o, S_IDLE);
      mem_ack_i = 0;

      // final report
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
